// File: rtl/systolic_row_feeder.sv
// Skewed left-edge operand feeder for the systolic array: holds a ROWS x K_DEPTH tile
// and streams lane r delayed by r cycles. Define FEEDER_ERR_EN to add the sticky err output.
module systolic_row_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4,
    parameter int K_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(ROWS)-1:0]      wr_row,
    input  logic [$clog2(K_DEPTH)-1:0]   wr_col,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         start,
    input  logic                         stall,
    output logic [ROWS*DATA_WIDTH-1:0]   data_out,
    output logic [ROWS-1:0]              valid_out,
    output logic                         busy,
`ifdef FEEDER_ERR_EN
    output logic                         err,
`endif
    output logic                         done
);

    localparam int TW = $clog2(ROWS + K_DEPTH);
    localparam int KW = $clog2(K_DEPTH);
    localparam logic [TW-1:0] LAST = TW'(ROWS + K_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         t_q, t_d;
    logic [DATA_WIDTH-1:0] mem_q [ROWS][K_DEPTH];
    logic                  wrInRange;

    assign wrInRange = (int'(wr_row) < ROWS) && (int'(wr_col) < K_DEPTH);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Tile writes are only accepted while idle so a running stream never sees a torn tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < K_DEPTH; k++)
                    mem_q[r][k] <= '0;
        end else if (wr_en && (state_q == IDLE) && wrInRange) begin
            mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    t_d     = '0;
                end
            end
            STREAM: begin
                if (!stall) begin
                    if (t_q == LAST) state_d = DONE;
                    else             t_d     = t_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane r sees element t-r while t lies inside [r, r+K_DEPTH); zero-padded elsewhere.
    for (genvar r = 0; r < ROWS; r++) begin : gLane
        logic          inWindow;
        logic [TW-1:0] offset;
        logic [KW-1:0] kIdx;

        assign offset   = t_q - TW'(r);
        assign kIdx     = offset[KW-1:0];
        assign inWindow = (state_q == STREAM) && (t_q >= TW'(r)) && (t_q < TW'(r + K_DEPTH));

        assign valid_out[r] = inWindow && !stall;
        assign data_out[r*DATA_WIDTH +: DATA_WIDTH] = inWindow ? mem_q[r][kIdx] : '0;
    end

`ifdef FEEDER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (((wr_en || start) && busy) || (wr_en && !wrInRange))
            err_q <= 1'b1;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Self-checking bench for systolic_row_feeder: directed and randomized stimulus against a
// cycle-count reference model of the skewed stream. Define FEEDER_ERR_EN to also check err.
module tb_systolic_row_feeder;

    localparam int DW   = 16;
    localparam int ROWS = 4;
    localparam int K    = 4;
    localparam int NBEAT = ROWS + K - 1;

    logic                clk = 1'b0;
    logic                reset, wr_en, start, stall;
    logic [1:0]          wr_row, wr_col;
    logic [DW-1:0]       wr_data;
    logic [ROWS*DW-1:0]  data_out;
    logic [ROWS-1:0]     valid_out;
    logic                busy, done;
`ifdef FEEDER_ERR_EN
    logic                err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the tile plus "cycles since start" and "stalled cycles so far".
    logic [DW-1:0] mMem [ROWS][K];
    int            mSinceE = 0;
    int            mStalls = 0;
    logic          mErr    = 1'b0;

    systolic_row_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .K_DEPTH(K)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .stall(stall), .data_out(data_out),
        .valid_out(valid_out), .busy(busy),
`ifdef FEEDER_ERR_EN
        .err(err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Beat position = cycles since start minus stalls; -1 means idle.
    function automatic int beatPos();
        return (mSinceE == 0) ? -1 : (mSinceE - 1 - mStalls);
    endfunction

    task automatic checkOutput();
        int p;
        logic [ROWS*DW-1:0] eData;
        logic [ROWS-1:0]    eValid;
        logic               eBusy, eDone;
        p      = beatPos();
        eData  = '0;
        eValid = '0;
        eBusy  = (p >= 0);
        eDone  = (p == NBEAT);
        if (p >= 0 && p < NBEAT) begin
            for (int r = 0; r < ROWS; r++) begin
                if (p >= r && p < r + K) begin
                    eValid[r]           = !stall;
                    eData[r*DW +: DW]   = mMem[r][p-r];
                end
            end
        end
        check("busy", 128'(busy), 128'(eBusy));
        check("done", 128'(done), 128'(eDone));
        check("valid_out", 128'(valid_out), 128'(eValid));
        check("data_out", 128'(data_out), 128'(eData));
`ifdef FEEDER_ERR_EN
        check("err", 128'(err), 128'(mErr));
`endif
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, clock it, then advance the model.
    task automatic applyStimulus(input logic st, input logic we, input int row, input int col,
                                 input logic [DW-1:0] d, input logic sl, input logic rs);
        int  p;
        logic isBusy;
        start = st; wr_en = we; wr_row = row[1:0]; wr_col = col[1:0];
        wr_data = d; stall = sl; reset = rs;
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        p      = beatPos();
        isBusy = (p >= 0);
        if (rs) begin
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < K; k++)
                    mMem[r][k] = '0;
            mSinceE = 0;
            mStalls = 0;
            mErr    = 1'b0;
        end else begin
            if (((we || st) && isBusy) || (we && (row >= ROWS || col >= K))) mErr = 1'b1;
            if (!isBusy) begin
                if (we && row < ROWS && col < K) mMem[row][col] = d;
                if (st) begin
                    mSinceE = 1;
                    mStalls = 0;
                end
            end else if (p == NBEAT) begin
                mSinceE = 0;
            end else begin
                if (sl) mStalls++;
                mSinceE++;
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic loadPattern();
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < K; k++)
                applyStimulus(1'b0, 1'b1, r, k, 16'(16'h0010 * r + k), 1'b0, 1'b0);
    endtask

    // Run n cycles after start, stalling in the given cycle number after E (0 = never).
    task automatic runStream(input int n, input int stallCycle);
        for (int c = 0; c < n; c++)
            applyStimulus(1'b0, 1'b0, 0, 0, '0, (mSinceE == stallCycle) && stallCycle != 0, 1'b0);
    endtask

    initial begin
        start = 0; wr_en = 0; wr_row = 0; wr_col = 0; wr_data = 0; stall = 0; reset = 1;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < K; k++)
                mMem[r][k] = '0;
        @(posedge clk);
        #1;
        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b1);
        idleCycle();

        $display("[TB] plain stream");
        loadPattern();
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
        runStream(10, 0);

        $display("[TB] stall in cycle 3");
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
        runStream(11, 3);

        $display("[TB] start accepted under stall");
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b0);
        runStream(10, 0);

        $display("[TB] writes and restart while busy");
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 1, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 3, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
        runStream(8, 0);

        $display("[TB] write coincident with start");
        applyStimulus(1'b1, 1'b1, 2, 1, 16'hABCD, 1'b0, 1'b0);
        runStream(10, 0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b1);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
        runStream(10, 0);

        $display("[TB] randomized traffic");
        for (int run = 0; run < 4; run++) begin
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < K; k++)
                    applyStimulus(1'b0, 1'b1, r, k, 16'($urandom), 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
            for (int c = 0; c < 40; c++)
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                              int'($urandom_range(0, ROWS-1)), int'($urandom_range(0, K-1)),
                              16'($urandom), $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
